// File: rtl/collision_detect_pkg.sv
// Shared types and defaults for the flappy-bird collision/score engine.
package collision_detect_pkg;

  localparam int unsigned NUM_WALLS_DEF    = 4;
  localparam int unsigned X_W_DEF          = 8;
  localparam int unsigned Y_W_DEF          = 7;
  localparam int unsigned BIRD_W_DEF       = 4;
  localparam int unsigned BIRD_H_DEF       = 4;
  localparam int unsigned WALL_W_DEF       = 8;
  localparam int unsigned GAP_H_DEF        = 24;
  localparam int unsigned SCREEN_H_DEF     = 120;
  localparam int unsigned SCORE_DIGITS_DEF = 2;

  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BOUNDS = 2'd1,
    S_SCAN   = 2'd2,
    S_DONE   = 2'd3
  } cd_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/collision_detect_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; saturates at all nines.
module bcd_counter
  import collision_detect_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clr,
  input  logic                inc,
  output logic [4*DIGITS-1:0] count
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                all_nine;
  logic                carry;

  always_comb begin
    all_nine = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (count_q[4*i +: 4] != BCD_NINE) all_nine = 1'b0;
    end

    count_d = count_q;
    carry   = 1'b1;
    if (clr) begin
      count_d = '0;
    end else if (inc && !all_nine) begin
      // Ripple the +1 from digit 0 upward; a 9 rolls to 0 and passes the carry on.
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (count_q[4*i +: 4] == BCD_NINE) begin
            count_d[4*i +: 4] = '0;
          end else begin
            count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/collision_detect.sv
// Per-frame collision and score engine: snapshots positions, checks bounds,
// then scans one wall per cycle through a single shared comparator.
module collision_detect
  import collision_detect_pkg::*;
#(
  parameter int unsigned NUM_WALLS    = NUM_WALLS_DEF,
  parameter int unsigned X_W          = X_W_DEF,
  parameter int unsigned Y_W          = Y_W_DEF,
  parameter int unsigned BIRD_W       = BIRD_W_DEF,
  parameter int unsigned BIRD_H       = BIRD_H_DEF,
  parameter int unsigned WALL_W       = WALL_W_DEF,
  parameter int unsigned GAP_H        = GAP_H_DEF,
  parameter int unsigned SCREEN_H     = SCREEN_H_DEF,
  parameter int unsigned SCORE_DIGITS = SCORE_DIGITS_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      frame_done,
  input  logic [X_W-1:0]            bird_x,
  input  logic [Y_W-1:0]            bird_y,
  input  logic [NUM_WALLS*X_W-1:0]  wall_x,
  input  logic [NUM_WALLS*Y_W-1:0]  gap_y,
  output logic                      touched,
  output logic                      check_done,
  output logic                      busy,
  output logic [4*SCORE_DIGITS-1:0] score
);

  localparam int unsigned IDX_W = idx_width(NUM_WALLS);

  localparam logic [X_W:0]   BW_X  = (X_W+1)'(BIRD_W);
  localparam logic [X_W:0]   WW_X  = (X_W+1)'(WALL_W);
  localparam logic [Y_W:0]   BH_Y  = (Y_W+1)'(BIRD_H);
  localparam logic [Y_W:0]   GH_Y  = (Y_W+1)'(GAP_H);
  localparam logic [Y_W:0]   SH_Y  = (Y_W+1)'(SCREEN_H);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WALLS - 1);

  cd_state_e                state_q, state_d;
  logic [X_W-1:0]           bx_q, bx_d;
  logic [Y_W-1:0]           by_q, by_d;
  logic [NUM_WALLS*X_W-1:0] wx_q, wx_d;
  logic [NUM_WALLS*Y_W-1:0] gy_q, gy_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     hit_q, hit_d;
  logic                     touched_q, touched_d;
  logic [NUM_WALLS-1:0]     scored_q, scored_d;

  logic                     score_inc, score_clr;

  // Shared wall comparator, operands selected by idx.
  logic [X_W-1:0] wx_sel;
  logic [Y_W-1:0] gy_sel;
  logic [X_W:0]   bx_ext, wx_ext;
  logic [Y_W:0]   by_ext, gy_ext;
  logic           xov, yout, passed, respawn, bounds_hit, hit_cur;

  always_comb begin
    wx_sel     = wx_q[idx_q*X_W +: X_W];
    gy_sel     = gy_q[idx_q*Y_W +: Y_W];
    bx_ext     = {1'b0, bx_q};
    wx_ext     = {1'b0, wx_sel};
    by_ext     = {1'b0, by_q};
    gy_ext     = {1'b0, gy_sel};
    xov        = (bx_ext + BW_X > wx_ext) && (bx_ext < wx_ext + WW_X);
    yout       = (by_ext < gy_ext) || (by_ext + BH_Y > gy_ext + GH_Y);
    passed     = (wx_ext + WW_X <= bx_ext);
    respawn    = (wx_sel > bx_q);
    bounds_hit = (by_q == '0) || (by_ext + BH_Y > SH_Y);
    hit_cur    = hit_q | (xov & yout);
  end

  always_comb begin
    state_d   = state_q;
    bx_d      = bx_q;
    by_d      = by_q;
    wx_d      = wx_q;
    gy_d      = gy_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    touched_d = touched_q;
    scored_d  = scored_q;
    score_inc = 1'b0;
    score_clr = 1'b0;

    if (start) begin
      state_d   = S_IDLE;
      touched_d = 1'b0;
      scored_d  = '0;
      hit_d     = 1'b0;
      score_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (frame_done) begin
            bx_d    = bird_x;
            by_d    = bird_y;
            wx_d    = wall_x;
            gy_d    = gap_y;
            state_d = S_BOUNDS;
          end
        end
        S_BOUNDS: begin
          hit_d   = bounds_hit;
          idx_d   = '0;
          state_d = S_SCAN;
        end
        S_SCAN: begin
          hit_d = hit_cur;
          // A passed wall can never overlap in x, so hit_q alone gates scoring.
          if (passed && !scored_q[idx_q] && !touched_q && !hit_q) begin
            score_inc       = 1'b1;
            scored_d[idx_q] = 1'b1;
          end else if (respawn) begin
            scored_d[idx_q] = 1'b0;
          end
          if (idx_q == LAST_IDX) begin
            touched_d = touched_q | hit_cur;
            state_d   = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      bx_q      <= '0;
      by_q      <= '0;
      wx_q      <= '0;
      gy_q      <= '0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      touched_q <= 1'b0;
      scored_q  <= '0;
    end else begin
      state_q   <= state_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      wx_q      <= wx_d;
      gy_q      <= gy_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      touched_q <= touched_d;
      scored_q  <= scored_d;
    end
  end

  bcd_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .clk    (clk),
    .resetn (resetn),
    .clr    (score_clr),
    .inc    (score_inc),
    .count  (score)
  );

  assign touched    = touched_q;
  assign check_done = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_collision_detect.sv
// Directed bench for collision_detect: vector table of frames plus multi-cycle sequences.
module tb_collision_detect;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        frame_done = 1'b0;
  logic [7:0]  bird_x = '0;
  logic [6:0]  bird_y = '0;
  logic [31:0] wall_x = '0;
  logic [27:0] gap_y = '0;
  logic        touched, check_done, busy;
  logic [7:0]  score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collision_detect dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .frame_done (frame_done),
    .bird_x     (bird_x),
    .bird_y     (bird_y),
    .wall_x     (wall_x),
    .gap_y      (gap_y),
    .touched    (touched),
    .check_done (check_done),
    .busy       (busy),
    .score      (score)
  );

  typedef struct {
    bit          do_start;
    logic [7:0]  bx;
    logic [6:0]  by;
    logic [31:0] wx;
    logic [27:0] gy;
    logic        exp_touched;
    logic [7:0]  exp_score;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mkw(input int w0, input int w1, input int w2, input int w3);
    return {w3[7:0], w2[7:0], w1[7:0], w0[7:0]};
  endfunction

  function automatic logic [27:0] mkg(input int g);
    return {g[6:0], g[6:0], g[6:0], g[6:0]};
  endfunction

  task automatic add(input bit s, input int bx, input int by, input logic [31:0] wx,
                     input int g, input logic t, input logic [7:0] sc);
    vec_t v;
    v.do_start = s; v.bx = bx[7:0]; v.by = by[6:0]; v.wx = wx; v.gy = mkg(g);
    v.exp_touched = t; v.exp_score = sc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Returns edges from the frame_done sample edge to the first check_done cycle.
  task automatic run_frame(output int lat);
    @(negedge clk); frame_done = 1'b1;
    @(negedge clk); frame_done = 1'b0;
    lat = 0;
    while (!check_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic set_pos(input int bx, input int by, input logic [31:0] wx, input int g);
    bird_x = bx[7:0]; bird_y = by[6:0]; wall_x = wx; gap_y = mkg(g);
  endtask

  int lat, cnt, first;

  initial begin
    add(1, 20, 50,  mkw(200, 200, 200, 200), 60, 1'b0, 8'h00);
    add(0, 20, 50,  mkw(200,  18, 200, 200), 60, 1'b1, 8'h00);
    add(0, 20, 50,  mkw(200, 200, 200, 200), 60, 1'b1, 8'h00);
    add(0, 20, 50,  mkw(200, 200, 200, 200), 60, 1'b1, 8'h00);
    add(0, 20, 50,  mkw(200, 200, 200, 200), 60, 1'b1, 8'h00);
    add(1, 20, 117, mkw(200, 200, 200, 200), 60, 1'b1, 8'h00);
    add(1, 20, 0,   mkw(200, 200, 200, 200), 60, 1'b1, 8'h00);
    add(1, 20, 116, mkw(200, 200, 200, 200), 60, 1'b0, 8'h00);
    add(0, 20, 50,  mkw(8,   200, 200, 200), 60, 1'b0, 8'h01);
    add(0, 20, 50,  mkw(8,   200, 200, 200), 60, 1'b0, 8'h01);
    add(0, 20, 50,  mkw(100, 200, 200, 200), 60, 1'b0, 8'h01);
    add(0, 20, 50,  mkw(8,   200, 200, 200), 60, 1'b0, 8'h02);
    add(0, 20, 50,  mkw(100,  18, 200, 200), 60, 1'b1, 8'h02);
    add(0, 20, 50,  mkw(8,   200, 200, 200), 60, 1'b1, 8'h02);
    add(1, 20, 0,   mkw(8,   200, 200, 200), 60, 1'b1, 8'h00);
    add(1, 20, 50,  mkw(12,  200, 200, 200), 60, 1'b0, 8'h01);
    add(0, 20, 50,  mkw(12,   24, 200, 200), 60, 1'b0, 8'h01);
    add(0, 20, 50,  mkw(12,   23, 200, 200), 60, 1'b1, 8'h01);
    add(1, 20, 60,  mkw(200,  18, 200, 200), 60, 1'b0, 8'h00);
    add(0, 20, 81,  mkw(200,  18, 200, 200), 60, 1'b1, 8'h00);

    repeat (3) @(negedge clk);
    chk("reset_touched", touched, 0);
    chk("reset_busy", busy, 0);
    chk("reset_check_done", check_done, 0);
    chk("reset_score", score, 0);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_start) do_start();
      set_pos(vecs[i].bx, vecs[i].by, vecs[i].wx, 0);
      gap_y = vecs[i].gy;
      run_frame(lat);
      chk($sformatf("v%0d_latency", i), lat, 5);
      chk($sformatf("v%0d_touched", i), touched, vecs[i].exp_touched);
      chk($sformatf("v%0d_score", i), score, vecs[i].exp_score);
    end

    // Score saturation: each pair of frames respawns then passes all four walls.
    do_start();
    chk("start_score", score, 0);
    chk("start_touched", touched, 0);
    for (int p = 1; p <= 26; p++) begin
      set_pos(20, 50, mkw(100, 100, 100, 100), 60);
      run_frame(lat);
      set_pos(20, 50, mkw(8, 8, 8, 8), 60);
      run_frame(lat);
      if (p == 1)  chk("sat_pair1", score, 8'h04);
      if (p == 3)  chk("sat_pair3_carry", score, 8'h12);
      if (p == 25) chk("sat_pair25", score, 8'h99);
      if (p == 26) chk("sat_hold", score, 8'h99);
    end
    do_start();
    chk("sat_start_score", score, 0);
    chk("sat_start_touched", touched, 0);
    chk("sat_start_idle", busy, 0);

    // frame_done re-pulsed while busy must be ignored.
    set_pos(20, 50, mkw(200, 200, 200, 200), 60);
    @(negedge clk); frame_done = 1'b1;
    @(negedge clk); frame_done = 1'b0;
    cnt = 0; first = 0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (check_done) begin
        cnt++;
        if (first == 0) first = n;
      end
      if (n == 1) frame_done = 1'b1;
      if (n == 2) frame_done = 1'b0;
    end
    chk("repulse_done_count", cnt, 1);
    chk("repulse_latency", first, 5);

    // start mid-scan aborts without check_done or touched.
    set_pos(20, 50, mkw(200, 18, 200, 200), 60);
    @(negedge clk); frame_done = 1'b1;
    @(negedge clk); frame_done = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("abort_busy", busy, 0);
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (check_done) cnt++;
    end
    chk("abort_done_count", cnt, 0);
    chk("abort_touched", touched, 0);

    // start wins over a same-cycle frame_done.
    @(negedge clk); start = 1'b1; frame_done = 1'b1;
    @(negedge clk); start = 1'b0; frame_done = 1'b0;
    chk("prio_busy", busy, 0);
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (check_done || busy) cnt++;
    end
    chk("prio_no_activity", cnt, 0);

    // Reset mid-scan clears everything at once.
    set_pos(20, 50, mkw(8, 200, 200, 200), 60);
    run_frame(lat);
    set_pos(20, 50, mkw(8, 18, 200, 200), 60);
    run_frame(lat);
    chk("prerst_touched", touched, 1);
    chk("prerst_score", score, 8'h01);
    @(negedge clk); frame_done = 1'b1;
    @(negedge clk); frame_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("prerst_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("rst_touched", touched, 0);
    chk("rst_score", score, 0);
    chk("rst_busy", busy, 0);
    chk("rst_check_done", check_done, 0);
    @(negedge clk); resetn = 1'b1;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (check_done) cnt++;
    end
    chk("rst_no_done", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
